j1_cpu: RTL and testbench
=========================

# j1_cpu

16-bit stack-machine Forth CPU (J1a class) executing one instruction per clock from a synchronous code memory. Data and return stacks are internal; code fetch, data memory and I/O are external ports. Instantiated as `j1` under the Forth system wrapper, which provides a dual-port synchronous RAM: port A for code and port B for data, with data read returning through `io_din`.

## Interface
- `LOG2ABITS`, 11: word-address width for code and data memory.
- `DWIDTH`, 16: data, instruction and stack width (fixed 16).

- `clk`  in  1: single clock, all state on the rising edge.
- `reset`  in  1: asynchronous, active-high; clears PC, stack pointers and T.
- `insn`  in  16: instruction at `pc`, from synchronous RAM addressed by `code_addr` on the previous edge.
- `code_addr`  out  LOG2ABITS: next PC (combinational), fetch address.
- `mem_addr`  out  LOG2ABITS: T[LOG2ABITS-1:0], data/I/O word address.
- `dout`  out  16: N, write data for memory and I/O.
- `mem_wr`  out  1: data memory write strobe.
- `io_wr`  out  1: I/O write strobe.
- `io_rd`  out  1: I/O read strobe.
- `io_din`  in  16: read data, memory or I/O, valid one cycle after address presented.

## Operation
- State: `pc`, T register, 16-entry circular data stack (N = top entry, 4-bit `dsp`), 16-entry circular return stack (R = top entry, 4-bit `rsp`). Pointers wrap silently; no overflow/underflow detection.
- Decode on `insn[15:13]`:
  - `1xx`: literal. Push {0, insn[14:0]}: T<=literal, N<=old T, dsp+1.
  - `000`: jump. pc<=insn[LOG2ABITS-1:0].
  - `001`: 0branch. If T==0, pc<=target, else pc+1. Always pop: T<=N, dsp-1.
  - `010`: call. Push pc+1 (zero-extended) to return stack, rsp+1, pc<=target.
  - `011`: ALU. The fields below apply.
- ALU fields:
  - `insn[12]`: R->PC. pc<=R[LOG2ABITS-1:0], else pc+1.
  - `insn[11:8]`: op giving new T.
  - `insn[6:4]`: function. 1 T->N, 2 T->R, 3 N->[T] (mem_wr), 4 N->io[T] (io_wr), 5 io read (io_rd).
  - `insn[3:2]`: rsp delta, 2-bit signed.
  - `insn[1:0]`: dsp delta, 2-bit signed.
  - `insn[7]`: reserved, ignored.
- ALU ops:
  - 0 T
  - 1 N
  - 2 T+N (mod 2^16)
  - 3 T&N
  - 4 T|N
  - 5 T^N
  - 6 ~T
  - 7 N==T, result all ones or 0
  - 8 N<T signed, all ones or 0
  - 9 T>>1 arithmetic
  - 10 T<<1
  - 11 R
  - 12 [T], i.e. io_din
  - 13 io[T], i.e. io_din
  - 14 {12'b0, dsp}
  - 15 N<T unsigned, all ones or 0
- Stack writes:
  - T->N writes old T at new dsp.
  - T->R writes old T at new rsp.
  - An ALU with neither T->N nor T->R leaves entries unchanged and only moves pointers.
- Strobes `mem_wr`, `io_wr` and `io_rd` are combinational from the current ALU `insn`. They are 0 for non-ALU instructions and while `reset`=1.

## Timing
- Reset values, asserted asynchronously:
  - pc=0, T=0, dsp=0, rsp=0.
  - code_addr=0, mem_addr=0, dout = stack content (don't care).
  - mem_wr=0, io_wr=0, io_rd=0.
- At least one clk edge is required during reset so `insn`=mem[0] on the first post-reset edge.
- One instruction per cycle. `code_addr` = next pc, so the sync RAM presents `insn` for the new pc on the following edge. No stalls.
- Memory/I/O read takes two instructions. The first holds the address in T, and the RAM registers mem[T] at the end of that cycle. The next instruction uses op 12 or 13 to load `io_din`.
- Writes: `mem_addr`/`dout`/`mem_wr` are valid during the cycle and captured by the RAM at the closing edge.
- Branch and return targets take effect the next cycle with no delay slot.

## Test plan
- Literals: 0x8005, 0x8003 -> T=3, N=5, dsp=2. Then 0x6203 (+, d-1) -> T=8, dsp=1.
- Call/return: call 0x4010 at pc=4 -> R=5, pc=0x10. At 0x10, ALU with R->PC and r-1 -> pc=5, rsp restored.
- 0branch: T=0 -> taken to target, dsp-1. T=1 -> pc+1, dsp-1.
- Memory: push 0x1234, push 0x0020, N->[T] -> mem_wr=1 for one cycle, mem_addr=0x020, dout=0x1234. Later T=0x0020, then op 12 -> T=0x1234.
- I/O and comparisons: N->io[T] pulses io_wr. Op 8 with N=0xFFFF, T=1 -> T=0xFFFF; op 15 on the same operands -> T=0. Op 9 on 0x8002 -> 0xC001.
- Reset mid-program: assert reset with a store instruction active -> strobes drop immediately, pc=0; after release execution restarts at address 0.

Source files
------------

// File: rtl/j1_cpu_if.sv
// Code/data/I-O bus between the j1 core and its dual-port synchronous RAM wrapper.
// Bus semantics: there is no valid/ready handshake. code_addr and mem_addr are
// presented every cycle, and the RAM answers on insn/io_din one clock later. The
// single-cycle strobes mem_wr, io_wr and io_rd qualify mem_addr/dout during the
// cycle in which they are high, and the slave acts on them at the closing edge.
interface j1_cpu_if #(
  parameter int LOG2ABITS = 11,
  parameter int DWIDTH    = 16
);
  logic [DWIDTH-1:0]    insn;
  logic [LOG2ABITS-1:0] code_addr;
  logic [LOG2ABITS-1:0] mem_addr;
  logic [DWIDTH-1:0]    dout;
  logic                 mem_wr;
  logic                 io_wr;
  logic                 io_rd;
  logic [DWIDTH-1:0]    io_din;

  modport master (
    input  insn, io_din,
    output code_addr, mem_addr, dout, mem_wr, io_wr, io_rd
  );

  modport slave (
    output insn, io_din,
    input  code_addr, mem_addr, dout, mem_wr, io_wr, io_rd
  );
endinterface

// File: rtl/j1_cpu.sv
// J1a-class 16-bit Forth stack CPU: one instruction per clock, with internal
// 16-deep circular data and return stacks, fetching code from a synchronous RAM.
module j1_cpu #(
  parameter int LOG2ABITS = 11,
  parameter int DWIDTH    = 16
) (
  input  logic     clk,
  input  logic     reset,
  j1_cpu_if.master bus
);

  localparam logic [LOG2ABITS-1:0] PC_ONE = LOG2ABITS'(1);

  logic [LOG2ABITS-1:0] pc, pc_next, pc_plus1;
  logic [DWIDTH-1:0]    t, t_next, n, r, alu, rwd;
  logic [3:0]           dsp, dsp_next, rsp, rsp_next;
  logic                 dwe, rwe;
  logic [DWIDTH-1:0]    dstack [16];
  logic [DWIDTH-1:0]    rstack [16];

  logic [DWIDTH-1:0]    insn;
  logic                 is_lit, is_alu;
  logic [2:0]           func;
  logic [3:0]           op;
  logic                 unused_ok;

  assign insn      = bus.insn;
  assign is_lit    = insn[15];
  assign is_alu    = (insn[15:13] == 3'b011);
  assign func      = insn[6:4];
  assign op        = insn[11:8];
  assign unused_ok = insn[7];

  assign n        = dstack[dsp];
  assign r        = rstack[rsp];
  assign pc_plus1 = pc + PC_ONE;

  always_comb begin
    alu = t;
    unique case (op)
      4'd0:  alu = t;
      4'd1:  alu = n;
      4'd2:  alu = t + n;
      4'd3:  alu = t & n;
      4'd4:  alu = t | n;
      4'd5:  alu = t ^ n;
      4'd6:  alu = ~t;
      4'd7:  alu = {DWIDTH{n == t}};
      4'd8:  alu = {DWIDTH{$signed(n) < $signed(t)}};
      4'd9:  alu = {t[DWIDTH-1], t[DWIDTH-1:1]};
      4'd10: alu = {t[DWIDTH-2:0], 1'b0};
      4'd11: alu = r;
      4'd12: alu = bus.io_din;
      4'd13: alu = bus.io_din;
      4'd14: alu = {{(DWIDTH-4){1'b0}}, dsp};
      4'd15: alu = {DWIDTH{n < t}};
    endcase
  end

  always_comb begin
    pc_next  = pc_plus1;
    t_next   = t;
    dsp_next = dsp;
    rsp_next = rsp;
    dwe      = 1'b0;
    rwe      = 1'b0;
    rwd      = t;
    if (is_lit) begin
      t_next   = {1'b0, insn[14:0]};
      dsp_next = dsp + 4'd1;
      dwe      = 1'b1;
    end else begin
      unique case (insn[14:13])
        2'b00: pc_next = insn[LOG2ABITS-1:0];
        2'b01: begin
          if (t == '0) pc_next = insn[LOG2ABITS-1:0];
          t_next   = n;
          dsp_next = dsp - 4'd1;
        end
        2'b10: begin
          rsp_next = rsp + 4'd1;
          rwe      = 1'b1;
          rwd      = {{(DWIDTH-LOG2ABITS){1'b0}}, pc_plus1};
          pc_next  = insn[LOG2ABITS-1:0];
        end
        2'b11: begin
          if (insn[12]) pc_next = r[LOG2ABITS-1:0];
          t_next   = alu;
          dsp_next = dsp + {{2{insn[1]}}, insn[1:0]};
          rsp_next = rsp + {{2{insn[3]}}, insn[3:2]};
          dwe      = (func == 3'd1);
          rwe      = (func == 3'd2);
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc  <= '0;
      t   <= '0;
      dsp <= '0;
      rsp <= '0;
    end else begin
      pc  <= pc_next;
      t   <= t_next;
      dsp <= dsp_next;
      rsp <= rsp_next;
    end
  end

  // Stack RAMs carry no reset; the entries are simply overwritten as the stacks are used.
  always_ff @(posedge clk) begin
    if (dwe && !reset) dstack[dsp_next] <= t;
    if (rwe && !reset) rstack[rsp_next] <= rwd;
  end

  assign bus.code_addr = reset ? '0 : pc_next;
  assign bus.mem_addr  = t[LOG2ABITS-1:0];
  assign bus.dout      = n;
  assign bus.mem_wr    = !reset && is_alu && (func == 3'd3);
  assign bus.io_wr     = !reset && is_alu && (func == 3'd4);
  assign bus.io_rd     = !reset && is_alu && (func == 3'd5);

endmodule

// File: tb/tb_j1_cpu.sv
// Testbench for j1_cpu: a directed program table from reset, a mid-program reset,
// and a random program checked cycle by cycle against an instruction-level model.
module tb_j1_cpu;
  localparam int A = 11;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  j1_cpu_if #(.LOG2ABITS(A), .DWIDTH(16)) bus ();
  j1_cpu #(.LOG2ABITS(A), .DWIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [15:0] prog [2048];
  logic [15:0] ram  [2048];

  // Dual-port synchronous RAM: read-first on the data port.
  always @(posedge clk) begin
    bus.insn   <= prog[bus.code_addr];
    bus.io_din <= ram[bus.mem_addr];
    if (bus.mem_wr) ram[bus.mem_addr] <= bus.dout;
  end

  int checks = 0;
  int errors = 0;
  logic [26:0] exp_q[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outputs(input string tag, input logic [10:0] ca, input logic [10:0] ma,
                             input logic [15:0] dout, input bit dv, input logic [2:0] strb);
    chk({tag, " code_addr"}, {5'b0, bus.code_addr}, {5'b0, ca});
    chk({tag, " mem_addr"}, {5'b0, bus.mem_addr}, {5'b0, ma});
    if (dv) chk({tag, " dout"}, bus.dout, dout);
    chk({tag, " strobes"}, {13'b0, bus.mem_wr, bus.io_wr, bus.io_rd}, {13'b0, strb});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " code_addr"}, {5'b0, bus.code_addr}, 16'h0000);
    chk({tag, " mem_addr"}, {5'b0, bus.mem_addr}, 16'h0000);
    chk({tag, " strobes"}, {13'b0, bus.mem_wr, bus.io_wr, bus.io_rd}, 16'h0000);
  endtask

  // ---------------- instruction-level reference model ----------------
  logic [10:0] m_pc;
  logic [15:0] m_t, m_din;
  logic [15:0] m_ds [16];
  logic [15:0] m_rs [16];
  bit          m_dv [16];
  int          m_dsp, m_rsp;
  logic [15:0] m_mem [2048];
  logic [10:0] e_ca, e_ma;
  logic [15:0] e_dout;
  bit          e_dv;
  logic [2:0]  e_strb;

  function automatic int to_signed(input logic [15:0] v);
    return (v >= 16'h8000) ? int'(v) - 65536 : int'(v);
  endfunction

  function automatic int delta2(input logic [1:0] f);
    return (f[1]) ? int'(f) - 4 : int'(f);
  endfunction

  task automatic model_reset();
    m_pc = '0; m_t = '0; m_dsp = 0; m_rsp = 0;
  endtask

  task automatic model_reset_edge();
    m_din = m_mem[0];
  endtask

  task automatic model_step(input logic [15:0] ins);
    logic [15:0] n, r, res, old_t, rd_val;
    logic [10:0] nxt;
    n      = m_ds[m_dsp];
    r      = m_rs[m_rsp];
    e_ma   = m_t[10:0];
    e_dout = n;
    e_dv   = m_dv[m_dsp];
    e_strb = 3'b000;
    rd_val = m_mem[m_t[10:0]];
    nxt    = m_pc + 11'd1;
    if (ins[15]) begin
      m_dsp = (m_dsp + 1) % 16;
      m_ds[m_dsp] = m_t;
      m_dv[m_dsp] = 1'b1;
      m_t = {1'b0, ins[14:0]};
    end else if (ins[14:13] == 2'b00) begin
      nxt = ins[10:0];
    end else if (ins[14:13] == 2'b01) begin
      if (m_t == 16'h0000) nxt = ins[10:0];
      m_t = n;
      m_dsp = (m_dsp + 15) % 16;
    end else if (ins[14:13] == 2'b10) begin
      m_rsp = (m_rsp + 1) % 16;
      m_rs[m_rsp] = {5'b0, m_pc + 11'd1};
      nxt = ins[10:0];
    end else begin
      case (ins[11:8])
        4'd0:  res = m_t;
        4'd1:  res = n;
        4'd2:  res = 16'(int'(m_t) + int'(n));
        4'd3:  res = m_t & n;
        4'd4:  res = m_t | n;
        4'd5:  res = m_t ^ n;
        4'd6:  res = ~m_t;
        4'd7:  res = (n == m_t) ? 16'hFFFF : 16'h0000;
        4'd8:  res = (to_signed(n) < to_signed(m_t)) ? 16'hFFFF : 16'h0000;
        4'd9:  res = 16'(to_signed(m_t) >>> 1);
        4'd10: res = 16'(int'(m_t) * 2);
        4'd11: res = r;
        4'd12: res = m_din;
        4'd13: res = m_din;
        4'd14: res = 16'(m_dsp);
        default: res = (int'(n) < int'(m_t)) ? 16'hFFFF : 16'h0000;
      endcase
      if (ins[12]) nxt = r[10:0];
      if (ins[6:4] == 3'd3) begin
        e_strb = 3'b100;
        m_mem[m_t[10:0]] = n;
        exp_q.push_back({m_t[10:0], n});
      end
      if (ins[6:4] == 3'd4) e_strb = 3'b010;
      if (ins[6:4] == 3'd5) e_strb = 3'b001;
      old_t = m_t;
      m_t   = res;
      m_dsp = (m_dsp + delta2(ins[1:0]) + 16) % 16;
      m_rsp = (m_rsp + delta2(ins[3:2]) + 16) % 16;
      if (ins[6:4] == 3'd1) begin m_ds[m_dsp] = old_t; m_dv[m_dsp] = 1'b1; end
      if (ins[6:4] == 3'd2) m_rs[m_rsp] = old_t;
    end
    m_din = rd_val;
    m_pc  = nxt;
    e_ca  = nxt;
  endtask

  function automatic logic [15:0] rand_insn();
    int k;
    logic [15:0] a;
    k = $urandom_range(0, 99);
    if (k < 30)      a = {1'b1, 15'($urandom)};
    else if (k < 38) a = {3'b000, 13'($urandom)};
    else if (k < 48) a = {3'b001, 13'($urandom)};
    else if (k < 56) a = {3'b010, 13'($urandom)};
    else begin
      a = {3'b011, 13'($urandom)};
      if ($urandom_range(0, 5) != 0) a[12] = 1'b0;
    end
    return a;
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [10:0] addr;
    logic [15:0] insn;
    logic [10:0] ca;
    logic [10:0] ma;
    logic [15:0] dout;
    bit          dv;
    logic [2:0]  strb;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [10:0] addr, input logic [15:0] insn,
                              input logic [10:0] ca, input logic [10:0] ma,
                              input logic [15:0] dout, input bit dv, input logic [2:0] strb);
    vec_t v;
    v.addr = addr; v.insn = insn; v.ca = ca; v.ma = ma;
    v.dout = dout; v.dv = dv; v.strb = strb;
    return v;
  endfunction

  initial begin
    vecs.push_back(mk(11'h000, 16'h8005, 11'h001, 11'h000, 16'h0000, 0, 3'b000));
    vecs.push_back(mk(11'h001, 16'h8003, 11'h002, 11'h005, 16'h0000, 1, 3'b000));
    vecs.push_back(mk(11'h002, 16'h6203, 11'h003, 11'h003, 16'h0005, 1, 3'b000));
    vecs.push_back(mk(11'h003, 16'h6011, 11'h004, 11'h008, 16'h0000, 1, 3'b000));
    vecs.push_back(mk(11'h004, 16'h6E11, 11'h005, 11'h008, 16'h0008, 1, 3'b000));
    vecs.push_back(mk(11'h005, 16'h6000, 11'h006, 11'h002, 16'h0008, 1, 3'b000));
    vecs.push_back(mk(11'h006, 16'h4010, 11'h010, 11'h002, 16'h0008, 1, 3'b000));
    vecs.push_back(mk(11'h010, 16'h700C, 11'h007, 11'h002, 16'h0008, 1, 3'b000));
    vecs.push_back(mk(11'h007, 16'h2040, 11'h008, 11'h002, 16'h0008, 1, 3'b000));
    vecs.push_back(mk(11'h008, 16'h8000, 11'h009, 11'h008, 16'h0008, 1, 3'b000));
    vecs.push_back(mk(11'h009, 16'h2030, 11'h030, 11'h000, 16'h0008, 1, 3'b000));
    vecs.push_back(mk(11'h030, 16'h9234, 11'h031, 11'h008, 16'h0008, 1, 3'b000));
    vecs.push_back(mk(11'h031, 16'h8020, 11'h032, 11'h234, 16'h0008, 1, 3'b000));
    vecs.push_back(mk(11'h032, 16'h6030, 11'h033, 11'h020, 16'h1234, 1, 3'b100));
    vecs.push_back(mk(11'h033, 16'h6000, 11'h034, 11'h020, 16'h1234, 1, 3'b000));
    vecs.push_back(mk(11'h034, 16'h6C00, 11'h035, 11'h020, 16'h1234, 1, 3'b000));
    vecs.push_back(mk(11'h035, 16'h6503, 11'h036, 11'h234, 16'h1234, 1, 3'b000));
    vecs.push_back(mk(11'h036, 16'h8000, 11'h037, 11'h000, 16'h0008, 1, 3'b000));
    vecs.push_back(mk(11'h037, 16'h6600, 11'h038, 11'h000, 16'h0000, 1, 3'b000));
    vecs.push_back(mk(11'h038, 16'h8001, 11'h039, 11'h7FF, 16'h0000, 1, 3'b000));
    vecs.push_back(mk(11'h039, 16'h6040, 11'h03A, 11'h001, 16'hFFFF, 1, 3'b010));
    vecs.push_back(mk(11'h03A, 16'h6811, 11'h03B, 11'h001, 16'hFFFF, 1, 3'b000));
    vecs.push_back(mk(11'h03B, 16'h6103, 11'h03C, 11'h7FF, 16'h0001, 1, 3'b000));
    vecs.push_back(mk(11'h03C, 16'h6F00, 11'h03D, 11'h001, 16'hFFFF, 1, 3'b000));
    vecs.push_back(mk(11'h03D, 16'hFFFD, 11'h03E, 11'h000, 16'hFFFF, 1, 3'b000));
    vecs.push_back(mk(11'h03E, 16'h6600, 11'h03F, 11'h7FD, 16'h0000, 1, 3'b000));
    vecs.push_back(mk(11'h03F, 16'h6900, 11'h040, 11'h002, 16'h0000, 1, 3'b000));
    vecs.push_back(mk(11'h040, 16'h6011, 11'h041, 11'h001, 16'h0000, 1, 3'b000));
    vecs.push_back(mk(11'h041, 16'h6050, 11'h042, 11'h001, 16'hC001, 1, 3'b001));
    vecs.push_back(mk(11'h042, 16'h6030, 11'h043, 11'h001, 16'hC001, 1, 3'b100));

    for (int i = 0; i < 2048; i++) begin prog[i] = 16'h0000; ram[i] = 16'h0000; end
    foreach (vecs[i]) prog[vecs[i].addr] = vecs[i].insn;

    // Reset state.
    reset = 1'b1;
    #1;
    chk_reset_outputs("reset");
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk_reset_outputs("reset held");
    reset = 1'b0;

    foreach (vecs[i]) begin
      #1;
      chk_outputs($sformatf("vec%0d@%h", i, vecs[i].addr), vecs[i].ca, vecs[i].ma,
                  vecs[i].dout, vecs[i].dv, vecs[i].strb);
      if (i < vecs.size() - 1) @(negedge clk);
    end

    // Reset lands while the final store is active: strobes drop at once, no write happens.
    reset = 1'b1;
    #1;
    chk_reset_outputs("midreset");
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    #1;
    chk_outputs("restart", vecs[0].ca, vecs[0].ma, 16'h0000, 0, 3'b000);
    chk("store suppressed", ram[1], 16'h0000);
    chk("stored word", ram[11'h020], 16'h1234);

    // ---------------- random program against the model ----------------
    for (int i = 0; i < 16; i++) prog[i] = {1'b1, 15'($urandom)};
    for (int i = 16; i < 32; i++) prog[i] = {5'b01000, 11'(i + 1)};
    for (int i = 32; i < 2048; i++) prog[i] = rand_insn();
    for (int i = 0; i < 2048; i++) begin ram[i] = 16'($urandom); m_mem[i] = ram[i]; end
    for (int i = 0; i < 16; i++) m_dv[i] = 1'b0;
    exp_q.delete();

    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(posedge clk); model_reset_edge();
    @(posedge clk); model_reset_edge();
    @(negedge clk);
    reset = 1'b0;

    for (int cyc = 0; cyc < 4000 && errors < 20; cyc++) begin
      #1;
      if (cyc == 2000) begin
        reset = 1'b1;
        #1;
        chk_reset_outputs("rand reset");
        model_reset();
        @(posedge clk); model_reset_edge();
        @(posedge clk); model_reset_edge();
        @(negedge clk);
        reset = 1'b0;
        continue;
      end
      model_step(prog[m_pc]);
      chk_outputs($sformatf("rand%0d", cyc), e_ca, e_ma, e_dout, e_dv, e_strb);
      if (bus.mem_wr) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rand%0d store: got write %h<=%h, expected no write", cyc, bus.mem_addr, bus.dout);
        end else begin
          logic [26:0] w;
          w = exp_q.pop_front();
          if ({bus.mem_addr, bus.dout} !== w) begin
            errors++;
            $display("FAIL rand%0d store: got %h<=%h, expected %h<=%h", cyc, bus.mem_addr, bus.dout, w[26:16], w[15:0]);
          end
        end
      end
      @(negedge clk);
    end
    chk("store queue drained", 16'(exp_q.size()), 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
